// File: rtl/tx_8b10b_framer.sv
// tx_8b10b_framer: frames a byte stream into 8b10b symbols with SOF/EOF/abort and comma fill
module encode (
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout
);
  logic       k;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] n6, s6;
  logic [3:0] n4, s4;
  logic       unbal6, rd6, alt7, flip4, unbal4;
  assign k = datain[8];
  assign x = datain[4:0];
  assign y = datain[7:5];
  // RD- form of the 6b sub-block, bit 5 = a ... bit 0 = i
  always_comb begin
    n6 = 6'b000000;
    case (x)
      5'd0:  n6 = 6'b100111;
      5'd1:  n6 = 6'b011101;
      5'd2:  n6 = 6'b101101;
      5'd3:  n6 = 6'b110001;
      5'd4:  n6 = 6'b110101;
      5'd5:  n6 = 6'b101001;
      5'd6:  n6 = 6'b011001;
      5'd7:  n6 = 6'b111000;
      5'd8:  n6 = 6'b111001;
      5'd9:  n6 = 6'b100101;
      5'd10: n6 = 6'b010101;
      5'd11: n6 = 6'b110100;
      5'd12: n6 = 6'b001101;
      5'd13: n6 = 6'b101100;
      5'd14: n6 = 6'b011100;
      5'd15: n6 = 6'b010111;
      5'd16: n6 = 6'b011011;
      5'd17: n6 = 6'b100011;
      5'd18: n6 = 6'b010011;
      5'd19: n6 = 6'b110010;
      5'd20: n6 = 6'b001011;
      5'd21: n6 = 6'b101010;
      5'd22: n6 = 6'b011010;
      5'd23: n6 = 6'b111010;
      5'd24: n6 = 6'b110011;
      5'd25: n6 = 6'b100110;
      5'd26: n6 = 6'b010110;
      5'd27: n6 = 6'b110110;
      5'd28: n6 = k ? 6'b001111 : 6'b001110;
      5'd29: n6 = 6'b101110;
      5'd30: n6 = 6'b011110;
      5'd31: n6 = 6'b101011;
      default: n6 = 6'b000000;
    endcase
  end
  assign unbal6 = $countones(n6) != 3;
  assign s6     = (dispin && (unbal6 || x == 5'd7)) ? ~n6 : n6;
  assign rd6    = dispin ^ unbal6;
  // alternate x.7 avoids a run of five equal bits across the sub-block boundary
  assign alt7   = k || (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                            : (x == 5'd17 || x == 5'd18 || x == 5'd20));
  // RD- form of the 4b sub-block, bit 3 = f ... bit 0 = j
  always_comb begin
    n4 = 4'b0000;
    case (y)
      3'd0: n4 = 4'b1011;
      3'd1: n4 = k ? 4'b0110 : 4'b1001;
      3'd2: n4 = k ? 4'b1010 : 4'b0101;
      3'd3: n4 = 4'b1100;
      3'd4: n4 = 4'b1101;
      3'd5: n4 = k ? 4'b0101 : 4'b1010;
      3'd6: n4 = k ? 4'b1001 : 4'b0110;
      3'd7: n4 = alt7 ? 4'b0111 : 4'b1110;
      default: n4 = 4'b0000;
    endcase
  end
  assign flip4   = k || y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7;
  assign unbal4  = y == 3'd0 || y == 3'd4 || y == 3'd7;
  assign s4      = (rd6 && flip4) ? ~n4 : n4;
  assign dispout = rd6 ^ unbal4;
  assign dataout = {s4[0], s4[1], s4[2], s4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
endmodule

module tx_8b10b_framer #(
  parameter int MIN_IDLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_en,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [9:0]  tx_sym,
  output logic        tx_valid,
  output logic        tx_rd,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_aborted
);
  localparam logic [8:0] K28_5 = 9'h1BC;
  localparam logic [8:0] K27_7 = 9'h1FB;
  localparam logic [8:0] K29_7 = 9'h1FD;
  localparam logic [8:0] K30_7 = 9'h1FE;
  typedef enum logic [2:0] {IDLE, SOF, DATA, EOF, DRAIN} state_t;
  state_t      state;
  logic        rd;
  logic [7:0]  idle_cnt;
  logic [7:0]  idle_next;
  logic        gap_ok;
  logic [8:0]  sym;
  logic [9:0]  enc_sym;
  logic        enc_rd;
  assign s_ready   = link_en && !rst && (state == DATA || state == DRAIN);
  assign idle_next = idle_cnt == 8'(MIN_IDLE) ? idle_cnt : idle_cnt + 8'd1;
  // the comma going out this cycle already counts toward the gap
  assign gap_ok    = {1'b0, idle_cnt} + 9'd1 >= 9'(MIN_IDLE);
  // symbol selection: everything outside a frame is comma fill
  always_comb sym = state == SOF  ? K27_7 :
                    state == EOF  ? K29_7 :
                    state == DATA ? (s_valid ? {1'b0, s_data} : K30_7) : K28_5;
  encode u_enc (
    .datain  (sym),
    .dispin  (rd),
    .dataout (enc_sym),
    .dispout (enc_rd)
  );
  // framing FSM, symbol register and counters; everything holds while link_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rd             <= 1'b0;
      idle_cnt       <= 8'd0;
      tx_sym         <= 10'd0;
      tx_valid       <= 1'b0;
      tx_rd          <= 1'b0;
      frames_sent    <= 16'd0;
      frames_aborted <= 16'd0;
    end else begin
      tx_valid <= link_en;
      if (link_en) begin
        tx_sym <= enc_sym;
        tx_rd  <= enc_rd;
        rd     <= enc_rd;
        case (state)
          IDLE: begin
            idle_cnt <= idle_next;
            if (s_valid && gap_ok) state <= SOF;
          end
          SOF: state <= DATA;
          DATA: begin
            if (!s_valid) begin
              state          <= DRAIN;
              idle_cnt       <= 8'd0;
              frames_aborted <= frames_aborted + 16'd1;
            end else if (s_last) state <= EOF;
          end
          EOF: begin
            state       <= IDLE;
            idle_cnt    <= 8'd0;
            frames_sent <= frames_sent + 16'd1;
          end
          DRAIN: begin
            idle_cnt <= idle_next;
            if (s_valid && s_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tx_8b10b_framer.sv
// tb_tx_8b10b_framer: scoreboard bench for the 8b10b link framer
module tb_tx_8b10b_framer;
  localparam logic [8:0] C   = 9'h1BC;
  localparam logic [8:0] SF  = 9'h1FB;
  localparam logic [8:0] EF  = 9'h1FD;
  localparam logic [8:0] AB  = 9'h1FE;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_en = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [9:0]  tx_sym;
  logic        tx_valid;
  logic        tx_rd;
  logic [15:0] frames_sent;
  logic [15:0] frames_aborted;
  int          vectors = 0;
  int          miscompares = 0;
  logic        mrd = 1'b0;
  logic [8:0]  mon_e;
  logic [8:0]  exp_q[$];

  tx_8b10b_framer #(.MIN_IDLE(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .link_en        (link_en),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .tx_sym         (tx_sym),
    .tx_valid       (tx_valid),
    .tx_rd          (tx_rd),
    .frames_sent    (frames_sent),
    .frames_aborted (frames_aborted)
  );

  always #5 clk = ~clk;

  // full codewords written as abcdei fghj, then reversed onto the {j..a} bus
  function automatic logic [9:0] code(input logic [8:0] s, input logic rd);
    logic [9:0] c;
    logic [9:0] r;
    case (s)
      C:       c = rd ? 10'b1100000101 : 10'b0011111010;
      SF:      c = rd ? 10'b0010010111 : 10'b1101101000;
      EF:      c = rd ? 10'b0100010111 : 10'b1011101000;
      AB:      c = rd ? 10'b1000010111 : 10'b0111101000;
      9'h000:  c = rd ? 10'b0110001011 : 10'b1001110100;
      9'h055:  c = 10'b1010100101;
      9'h0AA:  c = 10'b0101011010;
      9'h0FF:  c = rd ? 10'b0101001110 : 10'b1010110001;
      default: c = 'x;
    endcase
    for (int i = 0; i < 10; i++) r[i] = c[9 - i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream: unexpected symbol %b rd %b, required none", tx_sym, tx_rd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({tx_sym, tx_rd} !== {code(mon_e, mrd), mrd ^ (mon_e == C)}) begin
          miscompares++;
          $display("FAIL stream: sym %b rd %b, required %b rd %b (symbol %h)",
                   tx_sym, tx_rd, code(mon_e, mrd), mrd ^ (mon_e == C), mon_e);
        end
        mrd = mrd ^ (mon_e == C);
      end
    end
    if (rst) mrd = 1'b0;
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic [8:0] e);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    link_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({tx_sym, tx_valid, tx_rd, s_ready} !== 13'd0 || frames_sent !== 16'd0 || frames_aborted !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: sym %b valid %b rd %b ready %b sent %h abort %h, required all zero",
               tx_sym, tx_valid, tx_rd, s_ready, frames_sent, frames_aborted);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    link_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (s_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ready: s_ready %b, required 0", s_ready);
      end
      cyc(1'b0, 8'h00, 1'b0, C);
    end
  endtask

  task automatic test_basic_frame;
    logic [8:0] ex [7];
    logic [7:0] dd [7];
    bit         vv [7];
    bit         ll [7];
    bit         rr [7];
    int         ready_cycles;
    ex = '{C, SF, 9'h000, 9'h055, 9'h0AA, EF, C};
    dd = '{8'h00, 8'h00, 8'h00, 8'h55, 8'hAA, 8'h00, 8'h00};
    vv = '{1, 1, 1, 1, 1, 0, 0};
    ll = '{0, 0, 0, 0, 1, 0, 0};
    rr = '{0, 0, 1, 1, 1, 0, 0};
    ready_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (s_ready !== rr[i]) begin
        miscompares++;
        $display("FAIL basic_ready[%0d]: s_ready %b, required %b", i, s_ready, rr[i]);
      end
      if (s_ready === 1'b1) ready_cycles++;
      cyc(vv[i], dd[i], ll[i], ex[i]);
    end
    vectors++;
    if (ready_cycles != 3 || frames_sent !== 16'd1) begin
      miscompares++;
      $display("FAIL basic_count: ready cycles %0d sent %0d, required 3 and 1", ready_cycles, frames_sent);
    end
  endtask

  task automatic test_idle_gap;
    logic [7:0] b [3];
    b = '{8'h55, 8'hFF, 8'h00};
    repeat (3) cyc(1'b1, b[0], 1'b1, C);
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, b[f], 1'b1, SF);
      cyc(1'b1, b[f], 1'b1, {1'b0, b[f]});
      cyc(f < 2, f < 2 ? b[f + 1] : 8'h00, f < 2, EF);
      repeat (4) cyc(f < 2, f < 2 ? b[f + 1] : 8'h00, f < 2, C);
    end
    vectors++;
    if (frames_sent !== 16'd4) begin
      miscompares++;
      $display("FAIL gap_count: frames_sent %0d, required 4", frames_sent);
    end
  endtask

  task automatic test_underrun;
    logic [8:0] ex [13];
    logic [7:0] dd [13];
    bit         vv [13];
    bit         ll [13];
    bit         rr [13];
    ex = '{C, SF, 9'h000, 9'h055, AB, C, C, C, C, SF, 9'h0AA, EF, C};
    dd = '{8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'hAA, 8'hFF, 8'h55, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00};
    vv = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    ll = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    rr = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0};
    for (int i = 0; i < 13; i++) begin
      vectors++;
      if (s_ready !== rr[i]) begin
        miscompares++;
        $display("FAIL underrun_ready[%0d]: s_ready %b, required %b", i, s_ready, rr[i]);
      end
      cyc(vv[i], dd[i], ll[i], ex[i]);
      if (i == 4) begin
        vectors++;
        if (frames_aborted !== 16'd1) begin
          miscompares++;
          $display("FAIL underrun_abort: frames_aborted %0d, required 1", frames_aborted);
        end
      end
    end
    vectors++;
    if (frames_sent !== 16'd5 || frames_aborted !== 16'd1) begin
      miscompares++;
      $display("FAIL underrun_count: sent %0d aborted %0d, required 5 and 1", frames_sent, frames_aborted);
    end
  endtask

  task automatic test_freeze;
    repeat (3) cyc(1'b1, 8'h55, 1'b0, C);
    cyc(1'b1, 8'h55, 1'b0, SF);
    cyc(1'b1, 8'h55, 1'b0, 9'h055);
    link_en = 1'b0;
    s_data = 8'hAA;
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL freeze_ready: s_ready %b, required 0", s_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (tx_valid !== 1'b0 || s_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL freeze[%0d]: tx_valid %b s_ready %b, required 0 0", i, tx_valid, s_ready);
      end
    end
    link_en = 1'b1;
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL freeze_resume: s_ready %b, required 1", s_ready);
    end
    cyc(1'b1, 8'hAA, 1'b0, 9'h0AA);
    cyc(1'b1, 8'hFF, 1'b1, 9'h0FF);
    cyc(1'b0, 8'h00, 1'b0, EF);
    cyc(1'b0, 8'h00, 1'b0, C);
    vectors++;
    if (frames_sent !== 16'd6 || frames_aborted !== 16'd1) begin
      miscompares++;
      $display("FAIL freeze_count: sent %0d aborted %0d, required 6 and 1", frames_sent, frames_aborted);
    end
  endtask

  task automatic test_reset_mid;
    repeat (3) cyc(1'b1, 8'h00, 1'b0, C);
    cyc(1'b1, 8'h00, 1'b0, SF);
    cyc(1'b1, 8'h00, 1'b0, 9'h000);
    rst = 1'b1;
    s_data = 8'h55;
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready: s_ready %b, required 0", s_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (frames_sent !== 16'd0 || frames_aborted !== 16'd0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_counters: sent %0d aborted %0d valid %b, required 0 0 0",
               frames_sent, frames_aborted, tx_valid);
    end
    cyc(1'b0, 8'h00, 1'b0, C);
    vectors++;
    if (tx_sym !== 10'b0101111100 || tx_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_first: sym %b rd %b, required 0101111100 rd 1", tx_sym, tx_rd);
    end
    repeat (2) cyc(1'b0, 8'h00, 1'b0, C);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue: %0d symbols never produced, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_basic_frame;
    test_idle_gap;
    test_underrun;
    test_freeze;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
